// File: rtl/load_data_ext_pkg.sv
// Shared types and constants for the load data extension path.
// Optional feature macro: LOAD_DATA_EXT_ADEL_EN (address-error detection).
package load_data_ext_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LBU  = 3'b010;
  localparam logic [2:0] LD_LH   = 3'b011;
  localparam logic [2:0] LD_LHU  = 3'b100;
  localparam logic [2:0] LD_LW   = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic isLegalOp(input logic [2:0] op);
    return (op >= LD_LB) && (op <= LD_LW);
  endfunction

  // Halfwords need an even address, words a word-aligned one.
  function automatic logic isMisaligned(input logic [2:0] op, input logic [1:0] addrLo);
    return (((op == LD_LH) || (op == LD_LHU)) && addrLo[0]) ||
           ((op == LD_LW) && (addrLo != 2'b00));
  endfunction

endpackage

// File: rtl/load_data_ext_if.sv
// Request, memory-return and response signals of the load data extension block.
interface load_data_ext_if
  import load_data_ext_pkg::*;
#(
  parameter int TAG_W = 5
);

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        ld_op;
  logic [DATA_W-1:0] addr;
  logic [TAG_W-1:0]  req_tag;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic [TAG_W-1:0]  resp_tag;
  logic              misalign;
  logic              busy;

  modport master (
    output req_valid, ld_op, addr, req_tag, mem_rdata, mem_rvalid,
    input  req_ready, resp_valid, resp_data, resp_tag, misalign, busy
  );

  modport slave (
    input  req_valid, ld_op, addr, req_tag, mem_rdata, mem_rvalid,
    output req_ready, resp_valid, resp_data, resp_tag, misalign, busy
  );

endinterface

// File: rtl/load_data_ext_align.sv
// Combinational byte/halfword/word extraction with sign or zero extension.
module load_data_ext_align
  import load_data_ext_pkg::*;
(
  input  logic [2:0]        i_op,
  input  logic [1:0]        i_addrLo,
  input  logic [DATA_W-1:0] i_word,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_addrLo)
      2'b01:   w_byte = i_word[15:8];
      2'b10:   w_byte = i_word[23:16];
      2'b11:   w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase

    w_half = i_addrLo[1] ? i_word[31:16] : i_word[15:0];

    o_data = '0;
    case (i_op)
      LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  o_data = {24'd0, w_byte};
      LD_LH:   o_data = {{16{w_half[15]}}, w_half};
      LD_LHU:  o_data = {16'd0, w_half};
      LD_LW:   o_data = i_word;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/load_data_ext.sv
// M-stage load path: accepts one load, waits for memory, returns a registered tagged result.
// Optional feature macro: LOAD_DATA_EXT_ADEL_EN (misaligned lh/lhu/lw answer immediately with misalign=1).
module load_data_ext
  import load_data_ext_pkg::*;
#(
  parameter int TAG_W = 5
)(
  input  logic          clk,
  input  logic          reset,
  load_data_ext_if.slave bus
);

  state_t            r_state;
  state_t            w_nextState;
  logic [2:0]        r_op;
  logic [1:0]        r_addrLo;
  logic [TAG_W-1:0]  r_tag;
  logic [TAG_W-1:0]  r_respTag;
  logic [DATA_W-1:0] r_respData;
  logic              r_misalign;
  logic [DATA_W-1:0] w_alignData;
  logic              w_accept;
  logic              w_adel;
  logic              w_unusedAddr;

  // Only the byte offset matters; the upper address bits were used by memory.
  assign w_unusedAddr = ^bus.addr[DATA_W-1:2];

  assign w_accept = bus.req_valid && (r_state == ST_IDLE) && isLegalOp(bus.ld_op);

`ifdef LOAD_DATA_EXT_ADEL_EN
  assign w_adel = isMisaligned(bus.ld_op, bus.addr[1:0]);
`else
  assign w_adel = 1'b0;
`endif

  load_data_ext_align u_align (
    .i_op     (r_op),
    .i_addrLo (r_addrLo),
    .i_word   (bus.mem_rdata),
    .o_data   (w_alignData)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState    = r_state;
    bus.req_ready  = 1'b0;
    bus.busy       = 1'b0;
    bus.resp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (w_accept) begin
          w_nextState = w_adel ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        bus.busy = 1'b1;
        if (bus.mem_rvalid) begin
          w_nextState = ST_RESP;
        end
      end
      ST_RESP: begin
        bus.busy       = 1'b1;
        bus.resp_valid = 1'b1;
        w_nextState    = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Result registers are only written on completion, so they hold between loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op       <= LD_NONE;
      r_addrLo   <= 2'b00;
      r_tag      <= '0;
      r_respTag  <= '0;
      r_respData <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op     <= bus.ld_op;
        r_addrLo <= bus.addr[1:0];
        r_tag    <= bus.req_tag;
      end
      if (w_accept && w_adel) begin
        r_respData <= '0;
        r_respTag  <= bus.req_tag;
        r_misalign <= 1'b1;
      end else if ((r_state == ST_WAIT) && bus.mem_rvalid) begin
        r_respData <= w_alignData;
        r_respTag  <= r_tag;
        r_misalign <= 1'b0;
      end
    end
  end

  assign bus.resp_data = r_respData;
  assign bus.resp_tag  = r_respTag;
  assign bus.misalign  = r_misalign && (r_state == ST_RESP);

endmodule

// File: tb/tb_load_data_ext.sv
// Self-checking bench for load_data_ext: table of directed loads plus reset/illegal/back-to-back sequences.
// Expectations follow LOAD_DATA_EXT_ADEL_EN when it is defined.
module tb_load_data_ext;
  import load_data_ext_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [4:0]  tag;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] expData;
    logic        expMis;
    int          expLat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   nChecks = 0;
  int   nErrors = 0;
  vec_t vecs[13];

  always #5 clk = ~clk;

  load_data_ext_if #(.TAG_W(5)) bus ();

  load_data_ext #(.TAG_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    bus.req_valid  = 1'b0;
    bus.ld_op      = LD_NONE;
    bus.addr       = 32'h0;
    bus.req_tag    = 5'd0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
  endtask

  // Issue one load, return memory data after v.delay cycles, then check result and pulse shape.
  task automatic applyStimulus(input vec_t v, input string name);
    int          lat = 0;
    int          waitBad = 0;
    logic [31:0] gotData = 32'h0;
    logic [4:0]  gotTag = 5'd0;
    logic        gotMis = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.ld_op     = v.op;
    bus.addr      = v.addr;
    bus.req_tag   = v.tag;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.ld_op     = LD_NONE;
    bus.addr      = 32'hFFFF_FFFF;
    bus.req_tag   = 5'h1F;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      if (c == v.delay) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = v.rdata;
      end else begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'hA5A5_5A5A;
      end
      @(negedge clk);
      if (bus.resp_valid) begin
        lat     = c;
        gotData = bus.resp_data;
        gotTag  = bus.resp_tag;
        gotMis  = bus.misalign;
      end else if (!bus.busy || bus.req_ready) begin
        waitBad++;
      end
      @(posedge clk); #1;
    end
    bus.mem_rvalid = 1'b0;
    checkOutput({name, " latency"}, lat, v.expLat);
    checkOutput({name, " resp_data"}, gotData, v.expData);
    checkOutput({name, " resp_tag"}, {27'd0, gotTag}, {27'd0, v.tag});
    checkOutput({name, " misalign"}, {31'd0, gotMis}, {31'd0, v.expMis});
    checkOutput({name, " busy/ready while waiting"}, waitBad, 0);
    @(negedge clk);
    checkOutput({name, " resp_valid one-cycle"}, {31'd0, bus.resp_valid}, 32'd0);
    checkOutput({name, " resp_data held"}, bus.resp_data, v.expData);
    checkOutput({name, " req_ready after resp"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;
    //              op      addr          tag    rdata         dly expData       mis   lat
    vecs[0]  = '{LD_LB,  32'h0000_1001, 5'd3,  32'h1234_80FF, 1, 32'hFFFF_FF80, 1'b0, 2};
    vecs[1]  = '{LD_LBU, 32'h0000_2003, 5'd7,  32'hABCD_1234, 1, 32'h0000_00AB, 1'b0, 2};
    vecs[2]  = '{LD_LHU, 32'h0000_2002, 5'd8,  32'hABCD_1234, 1, 32'h0000_ABCD, 1'b0, 2};
    vecs[3]  = '{LD_LH,  32'h0000_3000, 5'd9,  32'h0000_8001, 4, 32'hFFFF_8001, 1'b0, 5};
    vecs[4]  = '{LD_LB,  32'h0000_0000, 5'd1,  32'h0000_007F, 1, 32'h0000_007F, 1'b0, 2};
    vecs[5]  = '{LD_LB,  32'h0000_0002, 5'd2,  32'h00FE_0000, 1, 32'hFFFF_FFFE, 1'b0, 2};
    vecs[6]  = '{LD_LH,  32'h0000_0002, 5'd31, 32'h7FFF_0000, 1, 32'h0000_7FFF, 1'b0, 2};
    vecs[7]  = '{LD_LBU, 32'h0000_0001, 5'd4,  32'h0000_F000, 1, 32'h0000_00F0, 1'b0, 2};
    vecs[8]  = '{LD_LW,  32'h0000_0100, 5'd5,  32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 1'b0, 3};
`ifdef LOAD_DATA_EXT_ADEL_EN
    vecs[9]  = '{LD_LW,  32'h0000_0102, 5'd13, 32'h1111_2222, 1, 32'h0000_0000, 1'b1, 1};
    vecs[10] = '{LD_LH,  32'h0000_0001, 5'd14, 32'h8000_FFFF, 1, 32'h0000_0000, 1'b1, 1};
    vecs[11] = '{LD_LHU, 32'h0000_0003, 5'd15, 32'h8000_0000, 1, 32'h0000_0000, 1'b1, 1};
`else
    vecs[9]  = '{LD_LW,  32'h0000_0102, 5'd13, 32'h1111_2222, 1, 32'h1111_2222, 1'b0, 2};
    vecs[10] = '{LD_LH,  32'h0000_0001, 5'd14, 32'h8000_FFFF, 1, 32'hFFFF_FFFF, 1'b0, 2};
    vecs[11] = '{LD_LHU, 32'h0000_0003, 5'd15, 32'h8000_0000, 1, 32'h0000_8000, 1'b0, 2};
`endif
    vecs[12] = '{LD_LB,  32'h0000_0003, 5'd16, 32'h8000_0000, 3, 32'hFFFF_FF80, 1'b0, 4};

    idleInputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    checkOutput("reset resp_data", bus.resp_data, 32'd0);
    checkOutput("reset resp_tag", {27'd0, bus.resp_tag}, 32'd0);
    checkOutput("reset misalign", {31'd0, bus.misalign}, 32'd0);
    checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset req_ready", {31'd0, bus.req_ready}, 32'd1);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // A request held during WAIT/RESP is taken only in the IDLE cycle after the response.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.ld_op = LD_LBU; bus.addr = 32'h0; bus.req_tag = 5'd10;
    @(posedge clk); #1;
    bus.ld_op = LD_LW; bus.addr = 32'h40; bus.req_tag = 5'd11;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.req_ready || !bus.busy || bus.resp_valid) bad++;
      @(posedge clk); #1;
    end
    checkOutput("b2b held in WAIT", bad, 0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_00C3;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("b2b first resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    checkOutput("b2b first resp_data", bus.resp_data, 32'h0000_00C3);
    checkOutput("b2b first resp_tag", {27'd0, bus.resp_tag}, 32'd10);
    checkOutput("b2b ready in RESP", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("b2b ready after resp", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("b2b busy after resp", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.ld_op = LD_NONE;
    @(negedge clk);
    checkOutput("b2b second accepted", {31'd0, bus.busy}, 32'd1);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("b2b second resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    checkOutput("b2b second resp_data", bus.resp_data, 32'hCAFE_F00D);
    checkOutput("b2b second resp_tag", {27'd0, bus.resp_tag}, 32'd11);

    // Reset while waiting: load discarded, stray memory return afterwards ignored.
    @(posedge clk); #1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.ld_op = LD_LW; bus.addr = 32'h0; bus.req_tag = 5'd6;
    @(posedge clk); #1;
    idleInputs();
    reset = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.resp_valid || bus.busy) bad++;
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
    end
    checkOutput("rst-in-wait no resp", bad, 0);
    checkOutput("rst-in-wait resp_data", bus.resp_data, 32'd0);
    checkOutput("rst-in-wait resp_tag", {27'd0, bus.resp_tag}, 32'd0);
    checkOutput("rst-in-wait misalign", {31'd0, bus.misalign}, 32'd0);
    checkOutput("rst-in-wait req_ready", {31'd0, bus.req_ready}, 32'd1);

    // Op 000 and illegal ops are dropped; mem_rvalid in IDLE is ignored.
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.ld_op      = (k == 0) ? 3'b000 : ((k == 1) ? 3'b110 : 3'b111);
      bus.addr       = 32'h0;
      bus.req_tag    = 5'd12;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h1234_5678;
      @(posedge clk); #1;
      idleInputs();
      repeat (2) begin
        @(negedge clk);
        if (bus.resp_valid || bus.busy || !bus.req_ready) bad++;
        @(posedge clk); #1;
      end
    end
    checkOutput("illegal ops dropped", bad, 0);
    checkOutput("illegal ops resp_data", bus.resp_data, 32'd0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
